multi_ball_hit_controller: RTL and testbench
============================================

Name: multi_ball_hit_controller

Overview:
- Parametrised successor of the two-ball hit controller: detects hole, border and ball-to-ball hits for NUM_BALLS balls from per-pixel draw-request overlap.
- Accumulates hits over one video frame, then resolves velocities once per frame in a sequential resolve pass, and publishes registered results with a valid pulse.
- Sits between the ball draw-request and position sources and the per-ball motion modules.

Parameters:
NUM_BALLS, 4, number of balls (2..8); index 0 is the white ball.
POS_W, 11, position width (unsigned).
VEL_W, 11, velocity width (signed two's complement).
HOLE_W, 3, hole number width.
BALL_SIZE, 32, ball bitmap edge in pixels.
TOP_OFFSET / DOWN_OFFSET / LEFT_OFFSET / RIGHT_OFFSET, 0 / 479 / 0 / 639, table border coordinates.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at frame start
ballDR  in  NUM_BALLS  per-ball draw request for the current pixel
bordersDR  in  1  border draw request
holesDR  in  1  hole draw request
holeNumber  in  HOLE_W  hole under the current pixel, valid with holesDR
ballPosX / ballPosY  in  NUM_BALLS*POS_W each  top-left positions, packed, ball i at [i*POS_W +: POS_W]
ballVelX / ballVelY  in  NUM_BALLS*VEL_W each  current velocities, packed
ballVelXOut / ballVelYOut  out  NUM_BALLS*VEL_W each  resolved velocities
ballCollision  out  NUM_BALLS  ball i received a new velocity
ballHoleHit  out  NUM_BALLS  ball i entered a hole
ballHoleNum  out  NUM_BALLS*HOLE_W  hole entered by ball i
borderCollisionOccurred / ballCollisionOccurred / holeCollisionOccurred  out  1 each  OR of the per-ball events this frame
outValid  out  1  one-cycle pulse; all outputs above are updated on this cycle

Behaviour:
- Reset: every output, latch, snapshot and the FSM go to 0 / IDLE. Reset mid-resolve abandons the pass with no outValid.
- Collect (every cycle, all states):
  - holeLatch[i] <= 1 and holeNumLatch[i] <= holeNumber when ballDR[i] && holesDR. The first hit in the frame wins the number.
  - borderLatch[i] is set by ballDR[i] && bordersDR.
  - pairLatch[i][j] (i<j) is set by ballDR[i] && ballDR[j].
- Frame boundary: on startOfFrame in IDLE, copy all latches plus ballPos*/ballVel* into snapshot registers and clear the latches in the same cycle. Pixel hits on that cycle go into the cleared latches. FSM moves to RESOLVE with idx=0.
- startOfFrame in RESOLVE/PUBLISH sets a pending flag; the snapshot is taken in the cycle after PUBLISH. Latches keep accumulating meanwhile. Only one pending frame is kept.
- RESOLVE: one ball per cycle, idx 0..NUM_BALLS-1, priority hole > border > ball.
  - Hole: velocity 0, holeHit=1, collision=0.
  - Border: negate X if posX <= LEFT_OFFSET+BALL_SIZE/2 with velX<0, or posX+BALL_SIZE >= RIGHT_OFFSET-BALL_SIZE/2 with velX>0. Y uses the same rule with TOP/DOWN. If neither axis qualifies, velocities pass through unchanged. collision=1.
  - Ball: partner = lowest-index j != i with the pair bit set whose own hole latch is clear. Ball i takes the partner's snapshot velocities (equal-mass swap). collision=1.
  - None: velocity unchanged, collision=0.
- Arithmetic: negation saturates; -(2^(VEL_W-1)) gives 2^(VEL_W-1)-1. Signed compare is used throughout.
- PUBLISH: results are held in result registers and copied to the outputs together. outValid=1 for exactly this cycle, and the aggregate flags are computed from the published vectors. FSM goes to IDLE. Outputs hold their values until the next PUBLISH.
- Latency: startOfFrame to outValid is NUM_BALLS+1 cycles.

Decomposition:
- Package hit_pkg: MAX_BALLS=8, the FSM state enum (IDLE, RESOLVE, PUBLISH), a sat_neg function, and the pair-index helper.
- Sub-module hit_latch_bank: the collect latches with snapshot-and-clear.

Test Plan:
- Reset: hold resetN=0 mid-RESOLVE -> all outputs 0 and no outValid after release until a new startOfFrame.
- Border: ball1 at posX=10, velX=-5 with bordersDR&&ballDR[1], then startOfFrame -> outValid 5 cycles later, ball1 velX=+5, ballCollision=4'b0010, borderCollisionOccurred=1.
- Pair swap: ballDR=4'b0101 overlap, ball0 vel (6,0), ball2 vel (-2,3) -> ball0 out (-2,3), ball2 out (6,0), ballCollisionOccurred=1.
- Hole priority: ball3 has hole 5 plus border in the same frame -> ballHoleHit[3]=1, ballHoleNum[3]=5, velocity 0, ballCollision[3]=0.
- Saturation: velX=-1024 at the left border -> velX out=1023.
- Pending frame: second startOfFrame arrives 2 cycles after the first -> two outValid pulses. Pixels latched during the first pass appear only in the second.

Source files
------------

// File: rtl/multi_ball_hit_controller_pkg.sv
`default_nettype none
// ============================================================================
// hit_pkg: shared FSM type and arithmetic/index helpers for the hit controller.
// Revision: 1.0
// ============================================================================
package hit_pkg;
  localparam int MAX_BALLS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Two's-complement negate of a w-bit value held sign-extended in 32 bits;
  // the most negative value maps to the most positive one.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
    logic signed [31:0] vmin;
    vmin = -(32'sd1 <<< (w - 1));
    if (v == vmin) return -(vmin + 32'sd1);
    return -v;
  endfunction

  function automatic int pair_idx(input int a, input int b, input int n);
    int lo;
    int hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/multi_ball_hit_controller_latch_bank.sv
`default_nettype none
// ============================================================================
// hit_latch_bank: per-frame hole/border/pair hit latches with snapshot-and-clear.
// Revision: 1.0
// ============================================================================
module hit_latch_bank
  import hit_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int HOLE_W    = 3
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          snap,
  input  logic [NUM_BALLS-1:0]          ballDR,
  input  logic                          bordersDR,
  input  logic                          holesDR,
  input  logic [HOLE_W-1:0]             holeNumber,
  output logic [NUM_BALLS-1:0]          snap_hole,
  output logic [NUM_BALLS-1:0]          snap_border,
  output logic [NUM_BALLS*HOLE_W-1:0]   snap_hole_num,
  output logic [NUM_BALLS*(NUM_BALLS-1)/2-1:0] snap_pair
);
  localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;

  logic [NUM_BALLS-1:0]        hole_latch, border_latch, hole_hit, border_hit;
  logic [NUM_BALLS*HOLE_W-1:0] hole_num_latch;
  logic [NUM_PAIRS-1:0]        pair_latch, pair_hit;

  assign hole_hit   = ballDR & {NUM_BALLS{holesDR}};
  assign border_hit = ballDR & {NUM_BALLS{bordersDR}};

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_pair_row
    for (genvar j = i + 1; j < NUM_BALLS; j++) begin : g_pair_col
      localparam int P = pair_idx(i, j, NUM_BALLS);
      assign pair_hit[P] = ballDR[i] & ballDR[j];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hole_latch     <= '0;
      border_latch   <= '0;
      pair_latch     <= '0;
      hole_num_latch <= '0;
      snap_hole      <= '0;
      snap_border    <= '0;
      snap_pair      <= '0;
      snap_hole_num  <= '0;
    end else begin
      if (snap) begin
        snap_hole     <= hole_latch;
        snap_border   <= border_latch;
        snap_pair     <= pair_latch;
        snap_hole_num <= hole_num_latch;
        hole_latch    <= hole_hit;
        border_latch  <= border_hit;
        pair_latch    <= pair_hit;
      end else begin
        hole_latch    <= hole_latch | hole_hit;
        border_latch  <= border_latch | border_hit;
        pair_latch    <= pair_latch | pair_hit;
      end
      // First hole hit of the frame owns the number; a snapshot clears it.
      for (int b = 0; b < NUM_BALLS; b++) begin
        if (hole_hit[b] && (snap || !hole_latch[b]))
          hole_num_latch[b*HOLE_W +: HOLE_W] <= holeNumber;
        else if (snap)
          hole_num_latch[b*HOLE_W +: HOLE_W] <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/multi_ball_hit_controller.sv
`default_nettype none
// ============================================================================
// multi_ball_hit_controller: per-frame hole/border/ball hit resolution for N balls.
// Revision: 1.0
// ============================================================================
module multi_ball_hit_controller
  import hit_pkg::*;
#(
  parameter int NUM_BALLS    = 4,
  parameter int POS_W        = 11,
  parameter int VEL_W        = 11,
  parameter int HOLE_W       = 3,
  parameter int BALL_SIZE    = 32,
  parameter int TOP_OFFSET   = 0,
  parameter int DOWN_OFFSET  = 479,
  parameter int LEFT_OFFSET  = 0,
  parameter int RIGHT_OFFSET = 639
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_BALLS-1:0]        ballDR,
  input  logic                        bordersDR,
  input  logic                        holesDR,
  input  logic [HOLE_W-1:0]           holeNumber,
  input  logic [NUM_BALLS*POS_W-1:0]  ballPosX,
  input  logic [NUM_BALLS*POS_W-1:0]  ballPosY,
  input  logic [NUM_BALLS*VEL_W-1:0]  ballVelX,
  input  logic [NUM_BALLS*VEL_W-1:0]  ballVelY,
  output logic [NUM_BALLS*VEL_W-1:0]  ballVelXOut,
  output logic [NUM_BALLS*VEL_W-1:0]  ballVelYOut,
  output logic [NUM_BALLS-1:0]        ballCollision,
  output logic [NUM_BALLS-1:0]        ballHoleHit,
  output logic [NUM_BALLS*HOLE_W-1:0] ballHoleNum,
  output logic                        borderCollisionOccurred,
  output logic                        ballCollisionOccurred,
  output logic                        holeCollisionOccurred,
  output logic                        outValid
);
  localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int IDX_W     = $clog2(NUM_BALLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, partner;
  logic pending, snap, resolving, publish, found;

  logic [NUM_BALLS-1:0]        snap_hole, snap_border;
  logic [NUM_BALLS*HOLE_W-1:0] snap_hole_num;
  logic [NUM_PAIRS-1:0]        snap_pair;
  logic [NUM_BALLS*POS_W-1:0]  snap_px, snap_py;
  logic [NUM_BALLS*VEL_W-1:0]  snap_vx, snap_vy;

  logic [POS_W-1:0]        pos_x [NUM_BALLS];
  logic [POS_W-1:0]        pos_y [NUM_BALLS];
  logic signed [VEL_W-1:0] vel_x [NUM_BALLS];
  logic signed [VEL_W-1:0] vel_y [NUM_BALLS];
  logic [HOLE_W-1:0]       hole_num [NUM_BALLS];

  logic signed [VEL_W-1:0] res_vx [NUM_BALLS];
  logic signed [VEL_W-1:0] res_vy [NUM_BALLS];
  logic [HOLE_W-1:0]       res_hnum [NUM_BALLS];
  logic [NUM_BALLS-1:0]    res_coll, res_hole, res_border, res_pair;
  logic [NUM_BALLS*VEL_W-1:0]  res_vx_p, res_vy_p;
  logic [NUM_BALLS*HOLE_W-1:0] res_hnum_p;

  logic signed [VEL_W-1:0] nvx, nvy;
  logic n_coll, n_hole, n_border, n_pair;
  int px, py, vx, vy;

  hit_latch_bank #(.NUM_BALLS(NUM_BALLS), .HOLE_W(HOLE_W)) u_latch_bank (
    .clk(clk), .resetN(resetN), .snap(snap), .ballDR(ballDR),
    .bordersDR(bordersDR), .holesDR(holesDR), .holeNumber(holeNumber),
    .snap_hole(snap_hole), .snap_border(snap_border),
    .snap_hole_num(snap_hole_num), .snap_pair(snap_pair)
  );

  for (genvar b = 0; b < NUM_BALLS; b++) begin : g_view
    assign pos_x[b]    = snap_px[b*POS_W +: POS_W];
    assign pos_y[b]    = snap_py[b*POS_W +: POS_W];
    assign vel_x[b]    = snap_vx[b*VEL_W +: VEL_W];
    assign vel_y[b]    = snap_vy[b*VEL_W +: VEL_W];
    assign hole_num[b] = snap_hole_num[b*HOLE_W +: HOLE_W];
    assign res_vx_p[b*VEL_W +: VEL_W]     = res_vx[b];
    assign res_vy_p[b*VEL_W +: VEL_W]     = res_vy[b];
    assign res_hnum_p[b*HOLE_W +: HOLE_W] = res_hnum[b];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap) state_nxt = RESOLVE;
      RESOLVE: if (idx == LAST_IDX) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap      = (state == IDLE) && (startOfFrame || pending);
    resolving = (state == RESOLVE);
    publish   = (state == PUBLISH);
  end

  // A frame start seen while busy is replayed right after PUBLISH.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx <= '0; pending <= 1'b0;
      snap_px <= '0; snap_py <= '0; snap_vx <= '0; snap_vy <= '0;
    end else begin
      if (snap) begin
        idx <= '0; pending <= 1'b0;
        snap_px <= ballPosX; snap_py <= ballPosY;
        snap_vx <= ballVelX; snap_vy <= ballVelY;
      end else begin
        if (resolving) idx <= idx + 1'b1;
        if (startOfFrame) pending <= 1'b1;
      end
    end
  end

  always_comb begin
    px = int'(pos_x[idx]); py = int'(pos_y[idx]);
    vx = int'(vel_x[idx]); vy = int'(vel_y[idx]);
    found = 1'b0; partner = '0;
    for (int j = 0; j < NUM_BALLS; j++) begin
      if (!found && j != int'(idx) && !snap_hole[j] &&
          snap_pair[pair_idx(j, int'(idx), NUM_BALLS)]) begin
        found = 1'b1; partner = IDX_W'(j);
      end
    end
    nvx = vel_x[idx]; nvy = vel_y[idx];
    n_coll = 1'b0; n_hole = 1'b0; n_border = 1'b0; n_pair = 1'b0;
    if (snap_hole[idx]) begin
      nvx = '0; nvy = '0; n_hole = 1'b1;
    end else if (snap_border[idx]) begin
      n_coll = 1'b1; n_border = 1'b1;
      if ((px <= LEFT_OFFSET + BALL_SIZE / 2 && vx < 0) ||
          (px + BALL_SIZE >= RIGHT_OFFSET - BALL_SIZE / 2 && vx > 0))
        nvx = VEL_W'(sat_neg(vx, VEL_W));
      if ((py <= TOP_OFFSET + BALL_SIZE / 2 && vy < 0) ||
          (py + BALL_SIZE >= DOWN_OFFSET - BALL_SIZE / 2 && vy > 0))
        nvy = VEL_W'(sat_neg(vy, VEL_W));
    end else if (found) begin
      nvx = vel_x[partner]; nvy = vel_y[partner];
      n_coll = 1'b1; n_pair = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int b = 0; b < NUM_BALLS; b++) begin
        res_vx[b] <= '0; res_vy[b] <= '0; res_hnum[b] <= '0;
      end
      res_coll <= '0; res_hole <= '0; res_border <= '0; res_pair <= '0;
    end else if (resolving) begin
      res_vx[idx]     <= nvx;
      res_vy[idx]     <= nvy;
      res_hnum[idx]   <= n_hole ? hole_num[idx] : '0;
      res_coll[idx]   <= n_coll;
      res_hole[idx]   <= n_hole;
      res_border[idx] <= n_border;
      res_pair[idx]   <= n_pair;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ballVelXOut <= '0; ballVelYOut <= '0; ballCollision <= '0;
      ballHoleHit <= '0; ballHoleNum <= '0; outValid <= 1'b0;
      borderCollisionOccurred <= 1'b0; ballCollisionOccurred <= 1'b0;
      holeCollisionOccurred   <= 1'b0;
    end else begin
      outValid <= publish;
      if (publish) begin
        ballVelXOut   <= res_vx_p;
        ballVelYOut   <= res_vy_p;
        ballCollision <= res_coll;
        ballHoleHit   <= res_hole;
        ballHoleNum   <= res_hnum_p;
        borderCollisionOccurred <= |res_border;
        ballCollisionOccurred   <= |res_pair;
        holeCollisionOccurred   <= |res_hole;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_multi_ball_hit_controller.sv
`default_nettype none
// ============================================================================
// tb_multi_ball_hit_controller: directed vector bench for the hit controller.
// Revision: 1.0
// ============================================================================
module tb_multi_ball_hit_controller;
  localparam int N  = 4;
  localparam int PW = 11;
  localparam int VW = 11;
  localparam int HW = 3;
  localparam int NV = 10;

  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0;
  logic bordersDR = 1'b0, holesDR = 1'b0;
  logic [N-1:0]    ballDR = '0;
  logic [HW-1:0]   holeNumber = '0;
  logic [N*PW-1:0] ballPosX = '0, ballPosY = '0;
  logic [N*VW-1:0] ballVelX = '0, ballVelY = '0;
  logic [N*VW-1:0] ballVelXOut, ballVelYOut;
  logic [N-1:0]    ballCollision, ballHoleHit;
  logic [N*HW-1:0] ballHoleNum;
  logic borderCollisionOccurred, ballCollisionOccurred, holeCollisionOccurred, outValid;

  int total = 0;
  int bad   = 0;

  multi_ball_hit_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
    .bordersDR(bordersDR), .holesDR(holesDR), .holeNumber(holeNumber),
    .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
    .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut), .ballCollision(ballCollision),
    .ballHoleHit(ballHoleHit), .ballHoleNum(ballHoleNum),
    .borderCollisionOccurred(borderCollisionOccurred),
    .ballCollisionOccurred(ballCollisionOccurred),
    .holeCollisionOccurred(holeCollisionOccurred), .outValid(outValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    dr1, dr2;
    logic            bd1, hd1, bd2, hd2;
    logic [HW-1:0]   hn1, hn2;
    logic [N*PW-1:0] pos_x, pos_y;
    logic [N*VW-1:0] vel_x, vel_y, exp_vx, exp_vy;
    logic [N-1:0]    exp_coll, exp_hole;
    logic [N*HW-1:0] exp_hnum;
    logic [2:0]      exp_flags;  // {border, ball, hole}
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [43:0] p4(input int a, input int b, input int c, input int d);
    return {11'(d), 11'(c), 11'(b), 11'(a)};
  endfunction

  function automatic logic [11:0] h4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t dflt();
    vec_t v;
    v.dr1 = '0; v.dr2 = '0; v.bd1 = 1'b0; v.hd1 = 1'b0; v.bd2 = 1'b0; v.hd2 = 1'b0;
    v.hn1 = '0; v.hn2 = '0;
    v.pos_x = p4(300, 300, 300, 300); v.pos_y = p4(200, 200, 200, 200);
    v.vel_x = p4(1, 2, 3, 4);         v.vel_y = p4(-1, -2, -3, -4);
    v.exp_vx = v.vel_x;               v.exp_vy = v.vel_y;
    v.exp_coll = '0; v.exp_hole = '0; v.exp_hnum = '0; v.exp_flags = 3'b000;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pixel(input logic [N-1:0] dr, input logic bd, input logic hd, input logic [HW-1:0] hn);
    ballDR = dr; bordersDR = bd; holesDR = hd; holeNumber = hn;
    tick();
    ballDR = '0; bordersDR = 1'b0; holesDR = 1'b0; holeNumber = '0;
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (outValid) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic check_outs(input string tag, input logic [N*VW-1:0] evx, input logic [N*VW-1:0] evy,
                            input logic [N-1:0] ecoll, input logic [N-1:0] ehole,
                            input logic [N*HW-1:0] ehnum, input logic [2:0] eflags);
    check({tag, " velx"}, 64'(ballVelXOut), 64'(evx));
    check({tag, " vely"}, 64'(ballVelYOut), 64'(evy));
    check({tag, " coll"}, 64'(ballCollision), 64'(ecoll));
    check({tag, " hole"}, 64'(ballHoleHit), 64'(ehole));
    check({tag, " hnum"}, 64'(ballHoleNum), 64'(ehnum));
    check({tag, " flags"}, 64'({borderCollisionOccurred, ballCollisionOccurred, holeCollisionOccurred}),
          64'(eflags));
  endtask

  initial begin
    vec_t v;
    int lat;
    int pulses;

    // Border hit on ball1 at the left edge, moving left.
    v = dflt(); v.dr1 = 4'b0010; v.bd1 = 1'b1;
    v.pos_x = p4(300, 10, 300, 300); v.vel_x = p4(1, -5, 3, 4); v.exp_vx = p4(1, 5, 3, 4);
    v.exp_coll = 4'b0010; v.exp_flags = 3'b100; vecs[0] = v;
    // Pair swap between balls 0 and 2.
    v = dflt(); v.dr1 = 4'b0101;
    v.vel_x = p4(6, 2, -2, 4); v.vel_y = p4(0, -2, 3, -4);
    v.exp_vx = p4(-2, 2, 6, 4); v.exp_vy = p4(3, -2, 0, -4);
    v.exp_coll = 4'b0101; v.exp_flags = 3'b010; vecs[1] = v;
    // Hole beats border on ball3.
    v = dflt(); v.dr1 = 4'b1000; v.bd1 = 1'b1; v.hd1 = 1'b1; v.hn1 = 3'd5;
    v.pos_x = p4(300, 300, 300, 10); v.vel_x = p4(1, 2, 3, -4);
    v.exp_vx = p4(1, 2, 3, 0); v.exp_vy = p4(-1, -2, -3, 0);
    v.exp_hole = 4'b1000; v.exp_hnum = h4(0, 0, 0, 5); v.exp_flags = 3'b001; vecs[2] = v;
    // Saturating negate of the most negative velocity.
    v = dflt(); v.dr1 = 4'b0001; v.bd1 = 1'b1;
    v.pos_x = p4(5, 300, 300, 300); v.vel_x = p4(-1024, 2, 3, 4); v.exp_vx = p4(1023, 2, 3, 4);
    v.exp_coll = 4'b0001; v.exp_flags = 3'b100; vecs[3] = v;
    // Border/hole pixels with no ball: nothing happens.
    v = dflt(); v.dr1 = 4'b0000; v.bd1 = 1'b1; v.hd1 = 1'b1; v.hn1 = 3'd7; vecs[4] = v;
    // Right/bottom thresholds hit exactly on ball2.
    v = dflt(); v.dr1 = 4'b0100; v.bd1 = 1'b1;
    v.pos_x = p4(300, 300, 591, 300); v.pos_y = p4(200, 200, 431, 200);
    v.vel_y = p4(-1, -2, 6, -4); v.exp_vx = p4(1, 2, -3, 4); v.exp_vy = p4(-1, -2, -6, -4);
    v.exp_coll = 4'b0100; v.exp_flags = 3'b100; vecs[5] = v;
    // Ball1 just outside the left threshold on X, exactly on the top threshold on Y.
    v = dflt(); v.dr1 = 4'b0010; v.bd1 = 1'b1;
    v.pos_x = p4(300, 17, 300, 300); v.pos_y = p4(200, 16, 200, 200);
    v.vel_x = p4(1, -5, 3, 4); v.exp_vx = p4(1, -5, 3, 4); v.exp_vy = p4(-1, 2, -3, -4);
    v.exp_coll = 4'b0010; v.exp_flags = 3'b100; vecs[6] = v;
    // Partner in a hole does not count as a ball collision.
    v = dflt(); v.dr1 = 4'b0011; v.dr2 = 4'b0010; v.hd2 = 1'b1; v.hn2 = 3'd2;
    v.exp_vx = p4(1, 0, 3, 4); v.exp_vy = p4(-1, 0, -3, -4);
    v.exp_hole = 4'b0010; v.exp_hnum = h4(0, 2, 0, 0); v.exp_flags = 3'b001; vecs[7] = v;
    // Three-way overlap: each ball takes its lowest-index partner.
    v = dflt(); v.dr1 = 4'b0111;
    v.vel_x = p4(1, 2, 3, 9); v.vel_y = p4(1, 2, 3, 9);
    v.exp_vx = p4(2, 1, 1, 9); v.exp_vy = p4(2, 1, 1, 9);
    v.exp_coll = 4'b0111; v.exp_flags = 3'b010; vecs[8] = v;
    // First hole in a frame keeps its number.
    v = dflt(); v.dr1 = 4'b0001; v.hd1 = 1'b1; v.hn1 = 3'd3; v.dr2 = 4'b0001; v.hd2 = 1'b1; v.hn2 = 3'd6;
    v.exp_vx = p4(0, 2, 3, 4); v.exp_vy = p4(0, -2, -3, -4);
    v.exp_hole = 4'b0001; v.exp_hnum = h4(3, 0, 0, 0); v.exp_flags = 3'b001; vecs[9] = v;

    tick(); tick();
    check("reset outvalid", 64'(outValid), 64'd0);
    check_outs("reset", '0, '0, '0, '0, '0, 3'b000);
    resetN = 1'b1;
    tick();

    for (int k = 0; k < NV; k++) begin
      ballPosX = vecs[k].pos_x; ballPosY = vecs[k].pos_y;
      ballVelX = vecs[k].vel_x; ballVelY = vecs[k].vel_y;
      pixel(vecs[k].dr1, vecs[k].bd1, vecs[k].hd1, vecs[k].hn1);
      pixel(vecs[k].dr2, vecs[k].bd2, vecs[k].hd2, vecs[k].hn2);
      frame_pulse();
      wait_valid(lat);
      check($sformatf("v%0d latency", k), 64'(lat), 64'(N + 1));
      check_outs($sformatf("v%0d", k), vecs[k].exp_vx, vecs[k].exp_vy, vecs[k].exp_coll,
                 vecs[k].exp_hole, vecs[k].exp_hnum, vecs[k].exp_flags);
      tick();
      check($sformatf("v%0d pulse width", k), 64'(outValid), 64'd0);
    end

    // Reset in the middle of a resolve pass.
    ballPosX = p4(300, 10, 300, 300); ballPosY = p4(200, 200, 200, 200);
    ballVelX = p4(1, -5, 3, 4);       ballVelY = p4(1, 1, 1, 1);
    pixel(4'b0010, 1'b1, 1'b0, '0);
    frame_pulse();
    tick();
    resetN = 1'b0;
    #2;
    check_outs("midreset", '0, '0, '0, '0, '0, 3'b000);
    tick();
    resetN = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outValid) pulses++;
    end
    check("midreset no valid", 64'(pulses), 64'd0);

    // Second frame start arrives while the first is being resolved.
    ballPosX = p4(300, 10, 10, 300); ballVelX = p4(1, -5, -3, 4); ballVelY = p4(0, 0, 0, 0);
    pixel(4'b0010, 1'b1, 1'b0, '0);
    frame_pulse();
    pixel(4'b0100, 1'b1, 1'b0, '0);
    frame_pulse();
    wait_valid(lat);
    check("pending first latency", 64'(lat), 64'd3);
    check("pending first velx", 64'(ballVelXOut), 64'(p4(1, 5, -3, 4)));
    check("pending first coll", 64'(ballCollision), 64'(4'b0010));
    wait_valid(lat);
    check("pending second latency", 64'(lat), 64'd6);
    check("pending second velx", 64'(ballVelXOut), 64'(p4(1, -5, 3, 4)));
    check("pending second coll", 64'(ballCollision), 64'(4'b0100));
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outValid) pulses++;
    end
    check("pending no third", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
